// File: rtl/shared_mem_responder.sv
// Memory-side responder: a DEPTH x DATA_W word store behind the core request interface.
// One request is captured at a time and completed after LATENCY wait cycles.
module shared_mem_responder #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fetched_data,
  output logic              stall_cpu,
  output logic              resp_valid,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_M1  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                op_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   fetched_q;
  logic                resp_q;
  logic                err_q;
  logic [15:0]         rd_cnt_q;
  logic [15:0]         wr_cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req_s;
  logic                illegal_s;
  logic                done_d;
  logic                acc_we_d;
  logic [ADDR_W-1:0]   acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_d;
  logic                in_range_d;
  logic                mem_we_d;
  logic [DATA_W-1:0]   rd_data_d;

  // In IDLE a zero-latency access completes straight from the inputs; in BUSY only the captured copy is used.
  always_comb begin
    req_s     = read ^ write;
    illegal_s = read & write;
    if (state_q == IDLE) begin
      acc_we_d    = write;
      acc_addr_d  = address;
      acc_wdata_d = write_data;
      done_d      = req_s && (LATENCY == 0);
    end else begin
      acc_we_d    = op_we_q;
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
      done_d      = (cnt_q == 4'd0);
    end
    in_range_d = ({1'b0, acc_addr_d} < DEPTH_C);
    mem_we_d   = done_d & acc_we_d & in_range_d;
    if (in_range_d) begin
      rd_data_d = mem_q[acc_addr_d[IDX_W-1:0]];
    end else begin
      rd_data_d = {DATA_W{1'b0}};
    end
  end

  // Word store: no reset, and no commit while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we_d && resetn) begin
      mem_q[acc_addr_d[IDX_W-1:0]] <= acc_wdata_d;
    end
  end

  // Request FSM with the registered response, error flag and saturating counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      op_we_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      fetched_q <= {DATA_W{1'b0}};
      resp_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
    end else begin
      resp_q <= done_d;
      if ((state_q == IDLE) && illegal_s) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req_s) begin
            op_we_q <= write;
            addr_q  <= address;
            wdata_q <= write_data;
            if (LATENCY > 0) begin
              state_q <= BUSY;
              cnt_q   <= LAT_M1;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
      if (done_d) begin
        if (!in_range_d) begin
          err_q <= 1'b1;
        end
        if (acc_we_d) begin
          if (wr_cnt_q != 16'hFFFF) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
          end
        end else begin
          fetched_q <= rd_data_d;
          if (rd_cnt_q != 16'hFFFF) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  assign stall_cpu    = (state_q == BUSY);
  assign fetched_data = fetched_q;
  assign resp_valid   = resp_q;
  assign err          = err_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

endmodule
